// File: rtl/div_issue_if.sv
// Signal bundle for div_issue: decode-side enqueue, divider load/completion, completion tag
// and divide-by-zero bypass writeback. slave is the div_issue side, master the environment.
interface div_issue_if;
   // enq_valid/enq_ready: an entry transfers on a rising edge where both are high; the
   // producer keeps enq_valid and the enq_* fields stable until that edge, and enq_ready
   // never depends on enq_valid in the same cycle.
   logic        flush;
   logic        enq_valid;
   logic        enq_ready;
   logic [7:0]  enq_op;
   logic [63:0] enq_src1;
   logic [63:0] enq_src2;
   logic [4:0]  enq_rd;
   logic        div_valid;
   logic [7:0]  div_op;
   logic [63:0] div_src1;
   logic [63:0] div_src2;
   logic        div_done;
   logic        cmplt_valid;
   logic [4:0]  cmplt_rd;
   logic        wb_valid;
   logic [63:0] wb_res;
   logic [4:0]  wb_rd;

   modport master (
      output flush, enq_valid, enq_op, enq_src1, enq_src2, enq_rd, div_done,
      input  enq_ready, div_valid, div_op, div_src1, div_src2,
             cmplt_valid, cmplt_rd, wb_valid, wb_res, wb_rd
   );

   modport slave (
      input  flush, enq_valid, enq_op, enq_src1, enq_src2, enq_rd, div_done,
      output enq_ready, div_valid, div_op, div_src1, div_src2,
             cmplt_valid, cmplt_rd, wb_valid, wb_res, wb_rd
   );
endinterface

// File: rtl/div_issue.sv
// Divide-op issue queue: a DP-deep FIFO feeding a single iterative divider via IDLE/ISSUE/WAIT.
// Optional macro DIV_ZERO_BYPASS_EN retires divide-by-zero heads directly as a bypass writeback.
module div_issue #(
   parameter int DP = 4
) (
   input  logic       CLK,
   input  logic       RST,
   div_issue_if.slave bus,
   output logic [1:0] dbg_state
);
   localparam int AW = $clog2(DP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  fifo_op_q   [DP];
   logic [63:0] fifo_src1_q [DP];
   logic [63:0] fifo_src2_q [DP];
   logic [4:0]  fifo_rd_q   [DP];

   logic        div_valid_q, div_valid_d;
   logic [7:0]  div_op_q, div_op_d;
   logic [63:0] div_src1_q, div_src1_d;
   logic [63:0] div_src2_q, div_src2_d;
   logic [4:0]  inflight_rd_q, inflight_rd_d;
   logic        cmplt_valid_q, cmplt_valid_d;
   logic [4:0]  cmplt_rd_q, cmplt_rd_d;

   logic        empty, full, push, pop, head_bypass;
   logic [7:0]  head_op;
   logic [63:0] head_src1, head_src2;
   logic [4:0]  head_rd;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign bus.enq_ready = ~RST & ~full;
   assign push = bus.enq_valid & bus.enq_ready & ~bus.flush;

   assign head_op   = fifo_op_q[rd_ptr_q[AW-1:0]];
   assign head_src1 = fifo_src1_q[rd_ptr_q[AW-1:0]];
   assign head_src2 = fifo_src2_q[rd_ptr_q[AW-1:0]];
   assign head_rd   = fifo_rd_q[rd_ptr_q[AW-1:0]];

`ifdef DIV_ZERO_BYPASS_EN
   logic        head_is_w;
   logic [63:0] bypass_res;
   logic        wb_valid_q, wb_valid_d;
   logic [63:0] wb_res_q, wb_res_d;
   logic [4:0]  wb_rd_q, wb_rd_d;

   assign head_is_w   = |head_op[7:4];
   assign head_bypass = head_is_w ? (head_src2[31:0] == 32'd0) : (head_src2 == 64'd0);

   // Quotient by zero is all ones; remainder by zero is the dividend.
   always_comb begin
      bypass_res = '1;
      if (head_op[2] | head_op[3]) begin
         bypass_res = head_src1;
      end else if (head_op[6] | head_op[7]) begin
         bypass_res = {{32{head_src1[31]}}, head_src1[31:0]};
      end
   end

   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_res   = wb_res_q;
   assign bus.wb_rd    = wb_rd_q;
`else
   assign head_bypass  = 1'b0;
   assign bus.wb_valid = 1'b0;
   assign bus.wb_res   = 64'd0;
   assign bus.wb_rd    = 5'd0;
`endif

   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      div_valid_d   = 1'b0;
      div_op_d      = div_op_q;
      div_src1_d    = div_src1_q;
      div_src2_d    = div_src2_q;
      inflight_rd_d = inflight_rd_q;
      cmplt_valid_d = 1'b0;
      cmplt_rd_d    = cmplt_rd_q;
`ifdef DIV_ZERO_BYPASS_EN
      wb_valid_d    = 1'b0;
      wb_res_d      = wb_res_q;
      wb_rd_d       = wb_rd_q;
`endif
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (head_bypass) begin
`ifdef DIV_ZERO_BYPASS_EN
                  wb_valid_d = 1'b1;
                  wb_res_d   = bypass_res;
                  wb_rd_d    = head_rd;
`endif
               end else begin
                  div_op_d      = head_op;
                  div_src1_d    = head_src1;
                  div_src2_d    = head_src2;
                  inflight_rd_d = head_rd;
                  state_d       = ISSUE;
               end
            end
         end
         ISSUE: begin
            div_valid_d = 1'b1;
            state_d     = WAIT;
         end
         WAIT: begin
            if (bus.div_done) begin
               cmplt_valid_d = 1'b1;
               cmplt_rd_d    = inflight_rd_q;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

      // Flush drops everything; the divider operand registers keep their last load.
      if (bus.flush) begin
         state_d       = IDLE;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         div_valid_d   = 1'b0;
         div_op_d      = div_op_q;
         div_src1_d    = div_src1_q;
         div_src2_d    = div_src2_q;
         cmplt_valid_d = 1'b0;
         cmplt_rd_d    = cmplt_rd_q;
`ifdef DIV_ZERO_BYPASS_EN
         wb_valid_d    = 1'b0;
         wb_res_d      = wb_res_q;
         wb_rd_d       = wb_rd_q;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         div_valid_q   <= 1'b0;
         div_op_q      <= '0;
         div_src1_q    <= '0;
         div_src2_q    <= '0;
         inflight_rd_q <= '0;
         cmplt_valid_q <= 1'b0;
         cmplt_rd_q    <= '0;
`ifdef DIV_ZERO_BYPASS_EN
         wb_valid_q    <= 1'b0;
         wb_res_q      <= '0;
         wb_rd_q       <= '0;
`endif
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         div_valid_q   <= div_valid_d;
         div_op_q      <= div_op_d;
         div_src1_q    <= div_src1_d;
         div_src2_q    <= div_src2_d;
         inflight_rd_q <= inflight_rd_d;
         cmplt_valid_q <= cmplt_valid_d;
         cmplt_rd_q    <= cmplt_rd_d;
`ifdef DIV_ZERO_BYPASS_EN
         wb_valid_q    <= wb_valid_d;
         wb_res_q      <= wb_res_d;
         wb_rd_q       <= wb_rd_d;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_op_q[wr_ptr_q[AW-1:0]]   <= bus.enq_op;
         fifo_src1_q[wr_ptr_q[AW-1:0]] <= bus.enq_src1;
         fifo_src2_q[wr_ptr_q[AW-1:0]] <= bus.enq_src2;
         fifo_rd_q[wr_ptr_q[AW-1:0]]   <= bus.enq_rd;
      end
   end

   assign bus.div_valid   = div_valid_q;
   assign bus.div_op      = div_op_q;
   assign bus.div_src1    = div_src1_q;
   assign bus.div_src2    = div_src2_q;
   assign bus.cmplt_valid = cmplt_valid_q;
   assign bus.cmplt_rd    = cmplt_rd_q;
   assign dbg_state       = state_q;
endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue (DP=4): reset, single op, back-to-back fill, flush, bypass
// (or its absence when DIV_ZERO_BYPASS_EN is undefined) and reset in the middle of WAIT.
`timescale 1ns/1ps
module tb_div_issue;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  dbg_state;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];

   div_issue_if bus();

   div_issue #(.DP(4)) dut (
      .CLK       (clk),
      .RST       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush     = 1'b0;
      bus.enq_valid = 1'b0;
      bus.enq_op    = 8'd0;
      bus.enq_src1  = 64'd0;
      bus.enq_src2  = 64'd0;
      bus.enq_rd    = 5'd0;
      bus.div_done  = 1'b0;
   endtask

   task automatic drive_enq(input logic [7:0] op, input logic [63:0] s1, input logic [63:0] s2,
                            input logic [4:0] rd);
      bus.enq_valid = 1'b1;
      bus.enq_op    = op;
      bus.enq_src1  = s1;
      bus.enq_src2  = s2;
      bus.enq_rd    = rd;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      checks++; if (bus.enq_ready !== 1'b0) begin errors++; $display("FAIL rst_enq_ready got %b exp 0", bus.enq_ready); end
      checks++; if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL rst_div_valid got %b exp 0", bus.div_valid); end
      checks++; if (bus.div_src1 !== 64'd0) begin errors++; $display("FAIL rst_div_src1 got %h exp 0", bus.div_src1); end
      checks++; if (bus.cmplt_valid !== 1'b0) begin errors++; $display("FAIL rst_cmplt_valid got %b exp 0", bus.cmplt_valid); end
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %b exp 0", bus.wb_valid); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
      rst = 1'b0;
      #1;
      checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", bus.enq_ready); end
   endtask

   task automatic test_single_op();
      int bad;
      drive_enq(8'h02, 64'hFFFF_FFFF_FFFF_0000, 64'd1, 5'd5);
      tick();
      bus.enq_valid = 1'b0;
      checks++; if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 got %b exp 0", bus.div_valid); end
      tick();
      checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL single_issue_state got %0d exp 1", dbg_state); end
      checks++; if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL single_lat2 got %b exp 0", bus.div_valid); end
      tick();
      checks++; if (bus.div_valid !== 1'b1) begin errors++; $display("FAIL single_div_valid got %b exp 1", bus.div_valid); end
      checks++; if (bus.div_op !== 8'h02) begin errors++; $display("FAIL single_div_op got %h exp 02", bus.div_op); end
      checks++; if (bus.div_src1 !== 64'hFFFF_FFFF_FFFF_0000) begin errors++; $display("FAIL single_src1 got %h exp ffffffffffff0000", bus.div_src1); end
      checks++; if (bus.div_src2 !== 64'd1) begin errors++; $display("FAIL single_src2 got %h exp 1", bus.div_src2); end
      tick();
      checks++; if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b exp 0", bus.div_valid); end
      checks++; if (bus.div_src1 !== 64'hFFFF_FFFF_FFFF_0000) begin errors++; $display("FAIL single_src1_hold got %h exp ffffffffffff0000", bus.div_src1); end
      bad = 0;
      repeat (63) begin
         tick();
         if (bus.cmplt_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL single_early_cmplt got %0d exp 0", bad); end
      bus.div_done = 1'b1;
      tick();
      bus.div_done = 1'b0;
      checks++; if (bus.cmplt_valid !== 1'b1) begin errors++; $display("FAIL single_cmplt_valid got %b exp 1", bus.cmplt_valid); end
      checks++; if (bus.cmplt_rd !== 5'd5) begin errors++; $display("FAIL single_cmplt_rd got %0d exp 5", bus.cmplt_rd); end
      tick();
      checks++; if (bus.cmplt_valid !== 1'b0) begin errors++; $display("FAIL single_cmplt_width got %b exp 0", bus.cmplt_valid); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL single_back_idle got %0d exp 0", dbg_state); end
   endtask

   task automatic test_back_to_back();
      int bad;
      logic [63:0] exp_src;
      for (int i = 0; i < 5; i++) begin
         drive_enq(8'h01 << i, 64'd100 + 64'(i), 64'(i + 1), 5'(10 + i));
         exp_q.push_back(64'd100 + 64'(i));
         tick();
      end
      checks++; if (bus.enq_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", bus.enq_ready); end
      drive_enq(8'h02, 64'd999, 64'd7, 5'd31);
      tick();
      bus.enq_valid = 1'b0;
      checks++; if (bus.enq_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_full got %b exp 0", bus.enq_ready); end
      exp_src = exp_q.pop_front();
      checks++; if (bus.div_src1 !== exp_src) begin errors++; $display("FAIL b2b_first_src1 got %0d exp %0d", bus.div_src1, exp_src); end
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL b2b_wait_state got %0d exp 2", dbg_state); end
      for (int k = 1; k < 5; k++) begin
         bus.div_done = 1'b1;
         tick();
         bus.div_done = 1'b0;
         checks++; if (bus.cmplt_rd !== 5'(9 + k) || bus.cmplt_valid !== 1'b1) begin errors++; $display("FAIL b2b_cmplt got v%b rd %0d exp v1 rd %0d", bus.cmplt_valid, bus.cmplt_rd, 9 + k); end
         tick();
         tick();
         exp_src = exp_q.pop_front();
         checks++; if (bus.div_valid !== 1'b1 || bus.div_src1 !== exp_src) begin errors++; $display("FAIL b2b_order got v%b src1 %0d exp v1 src1 %0d", bus.div_valid, bus.div_src1, exp_src); end
         checks++; if (bus.div_op !== (8'h01 << k)) begin errors++; $display("FAIL b2b_op got %h exp %h", bus.div_op, 8'h01 << k); end
      end
      bus.div_done = 1'b1;
      tick();
      bus.div_done = 1'b0;
      checks++; if (bus.cmplt_rd !== 5'd14) begin errors++; $display("FAIL b2b_last_rd got %0d exp 14", bus.cmplt_rd); end
      bad = 0;
      repeat (4) begin
         tick();
         if (bus.div_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_sixth_dropped got %0d issues exp 0", bad); end
      checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL b2b_drained_ready got %b exp 1", bus.enq_ready); end
   endtask

   task automatic test_flush();
      int bad;
      drive_enq(8'h01, 64'h11, 64'd3, 5'd1);
      tick();
      drive_enq(8'h01, 64'h22, 64'd3, 5'd2);
      tick();
      drive_enq(8'h01, 64'h33, 64'd3, 5'd3);
      tick();
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL flush_pre_wait got %0d exp 2", dbg_state); end
      bus.flush = 1'b1;
      drive_enq(8'h01, 64'h44, 64'd3, 5'd4);
      tick();
      bus.flush     = 1'b0;
      bus.enq_valid = 1'b0;
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL flush_idle got %0d exp 0", dbg_state); end
      bad = 0;
      repeat (4) begin
         tick();
         if (bus.div_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL flush_fifo_empty got %0d issues exp 0", bad); end
      bus.div_done = 1'b1;
      tick();
      bus.div_done = 1'b0;
      checks++; if (bus.cmplt_valid !== 1'b0) begin errors++; $display("FAIL flush_stale_done got %b exp 0", bus.cmplt_valid); end
      drive_enq(8'h08, 64'h77, 64'd5, 5'd7);
      tick();
      bus.enq_valid = 1'b0;
      tick();
      tick();
      checks++; if (bus.div_valid !== 1'b1 || bus.div_src1 !== 64'h77) begin errors++; $display("FAIL flush_reissue got v%b src1 %h exp v1 src1 77", bus.div_valid, bus.div_src1); end
      bus.div_done = 1'b1;
      tick();
      bus.div_done = 1'b0;
      checks++; if (bus.cmplt_valid !== 1'b1 || bus.cmplt_rd !== 5'd7) begin errors++; $display("FAIL flush_reissue_cmplt got v%b rd %0d exp v1 rd 7", bus.cmplt_valid, bus.cmplt_rd); end
      tick();
   endtask

`ifdef DIV_ZERO_BYPASS_EN
   task automatic test_bypass();
      logic [7:0]  v_op   [3];
      logic [63:0] v_src1 [3];
      logic [63:0] v_src2 [3];
      logic [4:0]  v_rd   [3];
      logic [63:0] v_res  [3];
      int bad;
      v_op[0] = 8'h40; v_src1[0] = 64'h0000_0000_8000_0001; v_src2[0] = 64'd0; v_rd[0] = 5'd3; v_res[0] = 64'hFFFF_FFFF_8000_0001;
      v_op[1] = 8'h20; v_src1[1] = 64'd1234; v_src2[1] = 64'hFFFF_FFFF_0000_0000; v_rd[1] = 5'd9; v_res[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      v_op[2] = 8'h04; v_src1[2] = 64'h1234_5678_9ABC_DEF0; v_src2[2] = 64'd0; v_rd[2] = 5'd21; v_res[2] = 64'h1234_5678_9ABC_DEF0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         drive_enq(v_op[i], v_src1[i], v_src2[i], v_rd[i]);
         tick();
         bus.enq_valid = 1'b0;
         if (bus.div_valid !== 1'b0) bad++;
         tick();
         if (bus.div_valid !== 1'b0) bad++;
         checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== v_rd[i]) begin errors++; $display("FAIL bypass_wb got v%b rd %0d exp v1 rd %0d", bus.wb_valid, bus.wb_rd, v_rd[i]); end
         checks++; if (bus.wb_res !== v_res[i]) begin errors++; $display("FAIL bypass_res got %h exp %h", bus.wb_res, v_res[i]); end
         checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL bypass_stay_idle got %0d exp 0", dbg_state); end
         tick();
         if (bus.div_valid !== 1'b0) bad++;
         checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL bypass_pulse got %b exp 0", bus.wb_valid); end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL bypass_no_issue got %0d issues exp 0", bad); end
   endtask
`else
   task automatic test_no_bypass();
      int bad;
      bad = 0;
      drive_enq(8'h40, 64'h0000_0000_8000_0001, 64'd0, 5'd3);
      tick();
      bus.enq_valid = 1'b0;
      if (bus.wb_valid !== 1'b0) bad++;
      tick();
      if (bus.wb_valid !== 1'b0) bad++;
      tick();
      if (bus.wb_valid !== 1'b0) bad++;
      checks++; if (bus.div_valid !== 1'b1 || bus.div_op !== 8'h40) begin errors++; $display("FAIL nobypass_issue got v%b op %h exp v1 op 40", bus.div_valid, bus.div_op); end
      checks++; if (bus.div_src2 !== 64'd0) begin errors++; $display("FAIL nobypass_src2 got %h exp 0", bus.div_src2); end
      bus.div_done = 1'b1;
      tick();
      bus.div_done = 1'b0;
      if (bus.wb_valid !== 1'b0) bad++;
      checks++; if (bus.cmplt_valid !== 1'b1 || bus.cmplt_rd !== 5'd3) begin errors++; $display("FAIL nobypass_cmplt got v%b rd %0d exp v1 rd 3", bus.cmplt_valid, bus.cmplt_rd); end
      checks++; if (bad != 0) begin errors++; $display("FAIL nobypass_wb got %0d pulses exp 0", bad); end
      tick();
   endtask
`endif

   task automatic test_reset_mid();
      int bad;
      drive_enq(8'h10, 64'h55, 64'd3, 5'd12);
      tick();
      bus.enq_valid = 1'b0;
      tick();
      tick();
      checks++; if (dbg_state !== 2'd2 || bus.div_op !== 8'h10) begin errors++; $display("FAIL rstmid_pre got st %0d op %h exp st 2 op 10", dbg_state, bus.div_op); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (bus.div_valid !== 1'b0 || bus.div_op !== 8'd0) begin errors++; $display("FAIL rstmid_div got v%b op %h exp v0 op 00", bus.div_valid, bus.div_op); end
      checks++; if (bus.div_src1 !== 64'd0 || bus.div_src2 !== 64'd0) begin errors++; $display("FAIL rstmid_src got %h %h exp 0 0", bus.div_src1, bus.div_src2); end
      checks++; if (bus.cmplt_valid !== 1'b0 || bus.cmplt_rd !== 5'd0) begin errors++; $display("FAIL rstmid_cmplt got v%b rd %0d exp v0 rd 0", bus.cmplt_valid, bus.cmplt_rd); end
      checks++; if (bus.wb_valid !== 1'b0 || bus.wb_res !== 64'd0 || bus.wb_rd !== 5'd0) begin errors++; $display("FAIL rstmid_wb got v%b res %h rd %0d exp all 0", bus.wb_valid, bus.wb_res, bus.wb_rd); end
      checks++; if (bus.enq_ready !== 1'b1 || dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_ready got rdy %b st %0d exp rdy 1 st 0", bus.enq_ready, dbg_state); end
      bad = 0;
      bus.div_done = 1'b1;
      tick();
      bus.div_done = 1'b0;
      if (bus.cmplt_valid !== 1'b0) bad++;
      repeat (3) begin
         tick();
         if (bus.cmplt_valid !== 1'b0 || bus.div_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_done_ignored got %0d events exp 0", bad); end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_back_to_back();
      test_flush();
`ifdef DIV_ZERO_BYPASS_EN
      test_bypass();
`else
      test_no_bypass();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/div_issue.md
DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 SHALL have parameter DP, default 4, giving the operation FIFO depth (power of two, at least 2).
REQ-002 SHALL have port CLK  in  1  rising-edge clock.
REQ-003 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  in  1  discards all queued and in-flight ops.
REQ-005 SHALL have ports enq_valid in 1 and enq_ready out 1, the decode-side handshake.
REQ-006 SHALL have port enq_op  in  8  one-hot op: [0] div, [1] divu, [2] rem, [3] remu, [4] divw, [5] divuw, [6] remw, [7] remuw.
REQ-007 SHALL have ports enq_src1 in 64, enq_src2 in 64 and enq_rd in 5, carrying the operands and destination tag.
REQ-008 SHALL have port div_valid  out  1, a one-cycle load pulse to the divider.
REQ-009 SHALL have ports div_op out 8, div_src1 out 64 and div_src2 out 64, registered and held from the pulse until the next pulse.
REQ-010 SHALL have port div_done  in  1, the divider completion strobe.
REQ-011 SHALL have ports cmplt_valid out 1 and cmplt_rd out 5, the divider-op completion tag.
REQ-012 SHALL have ports wb_valid out 1, wb_res out 64 and wb_rd out 5, the bypass result.

Function
REQ-013 SHALL accept an entry on a cycle with enq_valid and enq_ready both high.
REQ-014 SHALL drive enq_ready as not-full, with no combinational path from enq_valid.
REQ-015 SHALL ignore enq_valid while the FIFO is full.
REQ-016 SHALL keep the FIFO pointers one bit wider than log2(DP): equal pointers mean empty; MSBs differing with the rest equal mean full; wrap-around is natural.
REQ-017 SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-018 IDLE with FIFO non-empty and the head not bypass-eligible SHALL register the head fields into div_*, pop the head, and go to ISSUE.
REQ-019 ISSUE SHALL assert div_valid for exactly one cycle and then go to WAIT.
REQ-020 WAIT SHALL hold until div_done, then pulse cmplt_valid with the in-flight tag on the next cycle and return to IDLE.
REQ-021 SHALL give a latency of 2 cycles from an accepting edge to div_valid when the FSM is in IDLE with the FIFO empty.
REQ-022 SHALL ignore div_done outside WAIT.
REQ-023 SHALL allow enqueue in every state, and allow enqueue together with pop in the same cycle.
REQ-024 flush SHALL empty the FIFO, force IDLE and suppress any pending cmplt_valid or wb_valid on the next cycle.
REQ-025 flush SHALL take priority over a simultaneous enqueue, and that enqueue is lost.
REQ-026 SHALL NOT need to abort the divider on flush, because the next div_valid reloads it.
REQ-027 SHALL pop in first-in, first-out order only.

Reset
REQ-028 RST SHALL empty the FIFO, set state IDLE, and clear div_valid, div_op, div_src1, div_src2, cmplt_valid, cmplt_rd, wb_valid, wb_res and wb_rd to 0.
REQ-029 RST SHALL hold enq_ready at 0 while asserted and at 1 from the first cycle after deassertion.
REQ-030 RST asserted mid-operation SHALL abandon the in-flight op with no cmplt_valid.
REQ-031 RST SHALL take priority over flush and over enqueue.

Configuration
REQ-032 SHALL compile the divide-by-zero bypass only when macro DIV_ZERO_BYPASS_EN is defined.
REQ-033 With DIV_ZERO_BYPASS_EN defined, a head is bypass-eligible when its divisor is zero: src2 == 0, or src2[31:0] == 0 for W ops.
REQ-034 With DIV_ZERO_BYPASS_EN defined, IDLE SHALL pop a bypass-eligible head without issuing it and stay in IDLE.
REQ-035 With DIV_ZERO_BYPASS_EN defined, the next cycle SHALL pulse wb_valid with wb_rd set to the head's rd.
REQ-036 The bypass wb_res SHALL be all ones for div, divu, divw and divuw.
REQ-037 The bypass wb_res SHALL be src1 for rem and remu, and src1[31:0] sign-extended to 64 bits for remw and remuw.
REQ-038 Without DIV_ZERO_BYPASS_EN, no head is bypass-eligible, and wb_valid, wb_res and wb_rd SHALL be tied to 0.

Verification
REQ-039 Bench: enqueue divu with src1=64'hFFFFFFFFFFFF0000, src2=1, rd=5 into an idle block -> div_valid 2 cycles later with div_src1/div_src2 matching; div_done after 65 cycles -> cmplt_valid with cmplt_rd=5 one cycle later.
REQ-040 Bench: enqueue 5 ops back-to-back while div_done is held low, DP=4 -> the first op issues, the next 4 fill the FIFO, enq_ready=0, the 6th op is not accepted, and issue order matches enqueue order.
REQ-041 Bench: enqueue remw with src2=0, src1=64'h0000_0000_8000_0001, rd=3, DIV_ZERO_BYPASS_EN defined -> no div_valid; wb_valid with wb_res=64'hFFFFFFFF80000001 and wb_rd=3.
REQ-042 Bench: repeat the REQ-041 stimulus without the macro -> div_valid issued; wb_valid stays 0.
REQ-043 Bench: flush during WAIT with 2 ops queued -> no cmplt_valid on a later div_done, the FIFO is empty, and the next enqueue issues normally.
REQ-044 Bench: assert RST mid-WAIT, then release -> all outputs 0, enq_ready=1, and a later div_done is ignored.
